mod_exp_lr: RTL and testbench

MOD_EXP_LR -- requirements
Module: mod_exp_lr

---
 rtl/mod_arith_pkg.sv | 20 ++
 rtl/mod_mul_il.sv | 76 +++++++
 rtl/mod_exp_lr.sv | 153 +++++++++++++++
 tb/tb_mod_exp_lr.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the modular-arithmetic blocks: exponentiator FSM
// encoding and the helper that sizes bit counters.
package mod_arith_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SQR_GO,
        ST_SQR_WAIT,
        ST_MUL_GO,
        ST_MUL_WAIT,
        ST_FIN
    } exp_state_t;

    // Width of a counter that must hold every value from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mod_mul_il.sv
// Bit-serial interleaved modular multiplier: y = a * b mod m.
// Processes one bit of b per cycle, MSB first: y = 2y mod m, then y += a mod m
// when the bit is set. Requires a < m and m >= 1; a and m are read live and
// must stay stable until done. b is captured when en is accepted.
// Handshake: en is honoured only while idle; done pulses for one cycle with y
// valid from that cycle until the next accepted en.
module mod_mul_il
    import mod_arith_pkg::*;
#(
    parameter int NBITS = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             done
);

    localparam int CW = cnt_width(NBITS);

    logic             busy_r;
    logic [CW-1:0]    cnt_r;
    logic [NBITS-1:0] y_r;
    logic [NBITS-1:0] b_sh;
    logic             done_r;

    // One extra bit of headroom: both 2y and y+a stay below 2m.
    logic [NBITS:0]   m_ext;
    logic [NBITS:0]   dbl;
    logic [NBITS:0]   dbl_red;
    logic [NBITS:0]   sum;
    logic [NBITS-1:0] y_step;

    // One interleaved step: double-and-reduce, then conditional add-and-reduce.
    always_comb begin
        m_ext   = {1'b0, m};
        dbl     = {y_r, 1'b0};
        dbl_red = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        sum     = dbl_red + (b_sh[NBITS-1] ? {1'b0, a} : '0);
        y_step  = (sum >= m_ext) ? NBITS'(sum - m_ext) : NBITS'(sum);
    end

    // Iteration control: load on en, run NBITS steps, pulse done on the last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            cnt_r  <= '0;
            y_r    <= '0;
            b_sh   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                y_r   <= y_step;
                b_sh  <= b_sh << 1;
                cnt_r <= cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (en) begin
                busy_r <= 1'b1;
                y_r    <= '0;
                b_sh   <= b;
                cnt_r  <= CW'(NBITS);
            end
        end
    end

    assign y    = y_r;
    assign done = done_r;

endmodule

// File: rtl/mod_exp_lr.sv
// Left-to-right square-and-multiply modular exponentiator: result = base^exp mod m.
// Leading zero exponent bits are skipped one per cycle in SCAN; the first set
// bit loads acc = base, and every following bit costs a square plus, when set,
// a multiply by base on the shared mod_mul_il instance.
// Handshake: start_p is a one-cycle request honoured only in IDLE; busy is high
// from the cycle after acceptance until completion; done_irq_p pulses once in
// FIN and result is updated at the end of that cycle, then held.
module mod_exp_lr
    import mod_arith_pkg::*;
#(
    parameter int NBITS = 4096,
    parameter int EBITS = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic [NBITS-1:0] base,
    input  logic [EBITS-1:0] exp,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] result,
    output logic             busy,
    output logic             done_irq_p
);

    localparam int CW = cnt_width(EBITS);

    exp_state_t       state, state_next;
    logic [NBITS-1:0] base_r, base_n;
    logic [NBITS-1:0] m_r, m_n;
    logic [EBITS-1:0] exp_r, exp_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic [NBITS-1:0] acc_r, acc_n;
    logic [NBITS-1:0] result_n;

    logic             mul_en;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_y;
    logic             mul_done;

    // Squares use acc for both operands; multiplies use the captured base.
    assign mul_b = (state == ST_MUL_GO || state == ST_MUL_WAIT) ? base_r : acc_r;

    mod_mul_il #(
        .NBITS(NBITS)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (mul_en),
        .a    (acc_r),
        .b    (mul_b),
        .m    (m_r),
        .y    (mul_y),
        .done (mul_done)
    );

    // Next-state and datapath updates; mul_en is a one-cycle pulse from the GO states.
    always_comb begin
        state_next = state;
        base_n     = base_r;
        m_n        = m_r;
        exp_n      = exp_r;
        cnt_n      = cnt_r;
        acc_n      = acc_r;
        result_n   = result;
        mul_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_p) begin
                    base_n     = base;
                    exp_n      = exp;
                    m_n        = m;
                    cnt_n      = CW'(EBITS);
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt_r == '0) begin
                    // Every bit scanned without a set one: exponent was zero.
                    acc_n      = (m_r == NBITS'(1)) ? '0 : NBITS'(1);
                    state_next = ST_FIN;
                end else if (!exp_r[EBITS-1]) begin
                    exp_n = exp_r << 1;
                    cnt_n = cnt_r - CW'(1);
                end else begin
                    acc_n      = base_r;
                    exp_n      = exp_r << 1;
                    cnt_n      = cnt_r - CW'(1);
                    state_next = (cnt_r == CW'(1)) ? ST_FIN : ST_SQR_GO;
                end
            end
            ST_SQR_GO: begin
                mul_en     = 1'b1;
                state_next = ST_SQR_WAIT;
            end
            ST_SQR_WAIT: begin
                if (mul_done) begin
                    acc_n = mul_y;
                    if (exp_r[EBITS-1]) begin
                        state_next = ST_MUL_GO;
                    end else begin
                        exp_n      = exp_r << 1;
                        cnt_n      = cnt_r - CW'(1);
                        state_next = (cnt_r == CW'(1)) ? ST_FIN : ST_SQR_GO;
                    end
                end
            end
            ST_MUL_GO: begin
                mul_en     = 1'b1;
                state_next = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (mul_done) begin
                    acc_n      = mul_y;
                    exp_n      = exp_r << 1;
                    cnt_n      = cnt_r - CW'(1);
                    state_next = (cnt_r == CW'(1)) ? ST_FIN : ST_SQR_GO;
                end
            end
            ST_FIN: begin
                result_n   = acc_r;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            base_r <= '0;
            m_r    <= '0;
            exp_r  <= '0;
            cnt_r  <= '0;
            acc_r  <= '0;
            result <= '0;
        end else begin
            state  <= state_next;
            base_r <= base_n;
            m_r    <= m_n;
            exp_r  <= exp_n;
            cnt_r  <= cnt_n;
            acc_r  <= acc_n;
            result <= result_n;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done_irq_p = (state == ST_FIN);

endmodule

// File: tb/tb_mod_exp_lr.sv
// Bench for mod_exp_lr at NBITS=8, EBITS=8: directed corner cases plus random
// operands, checked by a monitor against a repeated-multiplication model.
module tb_mod_exp_lr;

    localparam int NBITS = 8;
    localparam int EBITS = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_p = 1'b0;
    logic [NBITS-1:0] base_in = '0;
    logic [EBITS-1:0] e_in = '0;
    logic [NBITS-1:0] m_in = 8'd1;
    logic [NBITS-1:0] result;
    logic             busy;
    logic             done_irq_p;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int pushed = 0;
    int last_done_cyc = 0;
    logic [NBITS-1:0] exp_q[$];

    mod_exp_lr #(
        .NBITS(NBITS),
        .EBITS(EBITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_p   (start_p),
        .base      (base_in),
        .exp       (e_in),
        .m         (m_in),
        .result    (result),
        .busy      (busy),
        .done_irq_p(done_irq_p)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: base^e mod mm by plain repeated multiplication.
    function automatic logic [NBITS-1:0] model(input int b, input int e, input int mm);
        int r;
        r = 1 % mm;
        for (int i = 0; i < e; i++) r = (r * b) % mm;
        return NBITS'(r);
    endfunction

    // Monitor: on each completion pulse, pop the expected value and compare
    // the result presented in the following cycle.
    initial begin
        logic [NBITS-1:0] want;
        forever begin
            @(negedge clk);
            if (rst_n && done_irq_p) begin
                last_done_cyc = cyc;
                @(negedge clk);
                check("done_pulse_width", {31'd0, done_irq_p}, 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got result %0d, required no completion", result);
                end else begin
                    want = exp_q.pop_front();
                    check("result", {24'd0, result}, {24'd0, want});
                end
                done_cnt++;
            end
        end
    end

    // Driver: issue one start pulse, optionally queue the expected result,
    // wait (bounded) for completion and return the start-to-done latency.
    task automatic do_op(input int b, input int e, input int mm, output int lat);
        int t0;
        int d0;
        @(negedge clk);
        base_in = NBITS'(b);
        e_in    = EBITS'(e);
        m_in    = NBITS'(mm);
        start_p = 1'b1;
        t0 = cyc;
        d0 = done_cnt;
        exp_q.push_back(model(b, e, mm));
        pushed++;
        @(negedge clk);
        start_p = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        if (done_cnt == d0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no completion after 3000 cycles, required done_irq_p");
            lat = -1;
        end else begin
            lat = last_done_cyc - t0;
        end
    endtask

    initial begin
        int lat;
        int d0;
        int mm;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done_irq_p}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        d0 = done_cnt;
        do_op(4, 13, 13, lat);
        repeat (20) @(negedge clk);
        check("single_done_pulse", done_cnt - d0, 32'd1);
        do_op(2, 10, 251, lat);
        do_op(7, 0, 13, lat);
        check("exp0_latency", lat, 32'd10);
        do_op(7, 0, 1, lat);
        check("exp0_m1_latency", lat, 32'd10);
        do_op(9, 1, 13, lat);
        check("exp1_latency", lat, 32'd9);
        do_op(0, 200, 1, lat);

        // Start while busy on a long run is ignored.
        @(negedge clk);
        base_in = 8'd3; e_in = 8'd255; m_in = 8'd251; start_p = 1'b1;
        d0 = done_cnt;
        exp_q.push_back(model(3, 255, 251));
        pushed++;
        @(negedge clk);
        start_p = 1'b0;
        repeat (20) @(negedge clk);
        base_in = 8'd7; e_in = 8'd5; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        check("busy_start_ignored_done_count", done_cnt - d0, 32'd1);

        // Random operands.
        for (int k = 0; k < 30; k++) begin
            mm = $urandom_range(1, 255);
            do_op($urandom_range(0, mm - 1), $urandom_range(0, 255), mm, lat);
        end
        do_op(2, 10, 251, lat);

        // Reset while a square is in flight aborts the run silently.
        @(negedge clk);
        base_in = 8'd5; e_in = 8'd200; m_in = 8'd251; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_done", {31'd0, done_irq_p}, 32'd0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 32'd0);

        // Start during reset is ignored.
        @(negedge clk);
        rst_n = 1'b0; base_in = 8'd3; e_in = 8'd7; m_in = 8'd11; start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("start_in_reset_busy", {31'd0, busy}, 32'd0);

        // Fresh run after abort.
        do_op(3, 7, 11, lat);

        repeat (10) @(negedge clk);
        check("completions", done_cnt, pushed);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
